// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - VGA timing, per-frame board snapshot and 2-stage pixel pipeline
//
// Purpose: generates 640x480@60 VGA timing and hands vsync and framenumber to the game logic.
//   Once per frame, at the start of vertical blanking, it copies board_flat into an internal
//   snapshot. It then renders a framed 10x20 playfield from that snapshot only, so board updates
//   made during a frame cannot tear the image.
// Ports:
//   clock        in   1    pixel clock (25 MHz)
//   resetn       in   1    asynchronous, active-low reset
//   board_flat   in   600  cell (x,y) code at [(y*10+x)*3 +: 3]
//   hsync        out  1    horizontal sync, active low
//   vsync        out  1    vertical sync, active low
//   de           out  1    data enable (active area)
//   rgb          out  12   {R,G,B} 4 bits each
//   framenumber  out  10   frame counter, bumped with each snapshot
// Timing parameters may be reduced for fast simulation; counters are 10 bits wide, so the
// line and frame totals must stay at or below 1024.
module board_renderer #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CELL_LOG2 = 4,
  parameter int BOARD_X0  = 240,
  parameter int BOARD_Y0  = 80,
  parameter int BORDER_PX = 4
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic [599:0] board_flat,
  output logic         hsync,
  output logic         vsync,
  output logic         de,
  output logic [11:0]  rgb,
  output logic [9:0]   framenumber
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BOARD_W = 10 << CELL_LOG2;
  localparam int BOARD_H = 20 << CELL_LOG2;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] BX0      = 11'(BOARD_X0);
  localparam logic [10:0] BY0      = 11'(BOARD_Y0);
  localparam logic [10:0] FX0      = 11'(BOARD_X0 - BORDER_PX);
  localparam logic [10:0] FY0      = 11'(BOARD_Y0 - BORDER_PX);
  localparam logic [10:0] BW       = 11'(BOARD_W);
  localparam logic [10:0] BH       = 11'(BOARD_H);
  localparam logic [10:0] FW       = 11'(BOARD_W + 2 * BORDER_PX);
  localparam logic [10:0] FH       = 11'(BOARD_H + 2 * BORDER_PX);

  // ---------------- timing counters, snapshot, frame counter ----------------
  logic [9:0]   h_cnt_q, h_cnt_d;
  logic [9:0]   v_cnt_q, v_cnt_d;
  logic [599:0] snapshot_q, snapshot_d;
  logic [9:0]   frame_q, frame_d;
  logic         snap_now;

  always_comb begin
    h_cnt_d    = (h_cnt_q == H_LAST) ? 10'd0 : h_cnt_q + 10'd1;
    v_cnt_d    = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end
    // Snapshot and frame bump share one condition so they always update together.
    snap_now   = (h_cnt_q == 10'd0) && (v_cnt_q == V_ACT);
    snapshot_d = snap_now ? board_flat : snapshot_q;
    frame_d    = snap_now ? frame_q + 10'd1 : frame_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      snapshot_q <= '0;
      frame_q    <= '0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      snapshot_q <= snapshot_d;
      frame_q    <= frame_d;
    end
  end

  // ---------------- stage 1: geometry ----------------
  // Subtractions wrap for pixels left of / above an origin, giving large unsigned values
  // that fail the range compare, so one compare covers both bounds.
  logic [10:0] dx, dy, fx, fy;
  logic        in_board_d, in_border_d, gap_d, hs_n_d, vs_n_d, active_d;
  logic [3:0]  cx_d;
  logic [4:0]  cy_d;

  logic        s1_in_board_q, s1_in_border_q, s1_gap_q;
  logic        s1_hs_n_q, s1_vs_n_q, s1_active_q;
  logic [3:0]  s1_cx_q;
  logic [4:0]  s1_cy_q;

  always_comb begin
    dx          = {1'b0, h_cnt_q} - BX0;
    dy          = {1'b0, v_cnt_q} - BY0;
    fx          = {1'b0, h_cnt_q} - FX0;
    fy          = {1'b0, v_cnt_q} - FY0;
    in_board_d  = (dx < BW) && (dy < BH);
    in_border_d = (fx < FW) && (fy < FH) && !in_board_d;
    // Last pixel column/row of each cell is drawn as a grid line.
    gap_d       = (&dx[CELL_LOG2-1:0]) || (&dy[CELL_LOG2-1:0]);
    cx_d        = 4'(dx >> CELL_LOG2);
    cy_d        = 5'(dy >> CELL_LOG2);
    hs_n_d      = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    vs_n_d      = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    active_d    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s1_in_board_q  <= 1'b0;
      s1_in_border_q <= 1'b0;
      s1_gap_q       <= 1'b0;
      s1_cx_q        <= '0;
      s1_cy_q        <= '0;
      s1_hs_n_q      <= 1'b1;
      s1_vs_n_q      <= 1'b1;
      s1_active_q    <= 1'b0;
    end else begin
      s1_in_board_q  <= in_board_d;
      s1_in_border_q <= in_border_d;
      s1_gap_q       <= gap_d;
      s1_cx_q        <= cx_d;
      s1_cy_q        <= cy_d;
      s1_hs_n_q      <= hs_n_d;
      s1_vs_n_q      <= vs_n_d;
      s1_active_q    <= active_d;
    end
  end

  // ---------------- stage 2: cell lookup and colour ----------------
  logic [7:0]  cell_idx;
  logic [2:0]  code;
  logic [11:0] lut_rgb;
  logic [11:0] rgb_d;

  logic        hsync_q, vsync_q, de_q;
  logic [11:0] rgb_q;

  always_comb begin
    // Off-board pixels read cell 0 so the index never leaves the snapshot.
    cell_idx = s1_in_board_q ? (8'(s1_cy_q) * 8'd10 + 8'(s1_cx_q)) : 8'd0;
    code     = snapshot_q[{2'b00, cell_idx} * 10'd3 +: 3];
    case (code)
      3'b111:  lut_rgb = 12'h0FF;
      3'b100:  lut_rgb = 12'hF80;
      3'b001:  lut_rgb = 12'h00F;
      3'b010:  lut_rgb = 12'h0F0;
      3'b110:  lut_rgb = 12'hF00;
      3'b101:  lut_rgb = 12'hFF0;
      3'b011:  lut_rgb = 12'h80F;
      default: lut_rgb = 12'h000;
    endcase
    rgb_d = 12'h000;
    if (!s1_active_q)                 rgb_d = 12'h000;
    else if (s1_in_border_q)          rgb_d = 12'h888;
    else if (s1_in_board_q && s1_gap_q) rgb_d = 12'h111;
    else if (s1_in_board_q)           rgb_d = lut_rgb;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= 12'h000;
    end else begin
      hsync_q <= s1_hs_n_q;
      vsync_q <= s1_vs_n_q;
      de_q    <= s1_active_q;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign rgb         = rgb_q;
  assign framenumber = frame_q;

endmodule
